uart_tx_arb: RTL

Two-client transmit arbiter that shares a single UART transmitter between two requesters. Each client hands over a 16-bit word. The arbiter grants one client at a time and sends the word as two bytes, high byte first, by pulsing `trmt` and waiting for `tx_done` after each byte. It then returns a one-cycle completion pulse to the client. It sits between the command/telemetry producers and the UART `trmt`/`tx_data`/`tx_done` port.

---
 rtl/uart_tx_arb.sv | 106 ++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-client arbiter sharing one UART transmitter, sending each 16-bit word high byte first
// Ports: clk, rst_n (async, active-low); req0/data0, req1/data1 client requests and words;
//   done0/done1 one-cycle completion pulses; busy high outside IDLE;
//   trmt/tx_data byte strobe and byte to the UART; tx_done UART byte-finished level.
// Parameter GAP_CYCLES: idle clocks after each word before the next grant.
// Macro UART_ARB_RR_EN: round-robin tie break; undefined gives fixed priority to client 0.
module uart_tx_arb #(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [15:0] data1,
  input  logic        tx_done,
  output logic        done0,
  output logic        done1,
  output logic        busy,
  output logic        trmt,
  output logic [7:0]  tx_data
);
  typedef enum logic [2:0] {IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, GAP} state_t;
  state_t state, state_nx;
  logic [15:0] held, held_nx;
  logic [7:0] cnt, cnt_nx, tx_data_nx;
  logic id, id_nx, win, trmt_nx, done0_nx, done1_nx;
`ifdef UART_ARB_RR_EN
  logic last, last_nx;
  // on a tie client 1 wins only when client 0 was served last
  assign win = req1 & (~req0 | ~last);
`else
  assign win = req1 & ~req0;
`endif
  always_comb begin
    state_nx = state;
    held_nx = held;
    id_nx = id;
    cnt_nx = cnt;
    tx_data_nx = tx_data;
    trmt_nx = 1'b0;
    done0_nx = 1'b0;
    done1_nx = 1'b0;
`ifdef UART_ARB_RR_EN
    last_nx = last;
`endif
    case (state)
      IDLE: if (req0 | req1) begin
        held_nx = win ? data1 : data0;
        id_nx = win;
        tx_data_nx = win ? data1[15:8] : data0[15:8];
        trmt_nx = 1'b1;
        state_nx = SEND_HI;
      end
      // one cycle for the UART to clear the previous word's tx_done
      SEND_HI: state_nx = WAIT_HI;
      WAIT_HI: if (tx_done) begin
        tx_data_nx = held[7:0];
        trmt_nx = 1'b1;
        state_nx = SEND_LO;
      end
      SEND_LO: state_nx = WAIT_LO;
      WAIT_LO: if (tx_done) begin
        done0_nx = ~id;
        done1_nx = id;
`ifdef UART_ARB_RR_EN
        last_nx = id;
`endif
        state_nx = GAP_CYCLES > 0 ? GAP : IDLE;
        cnt_nx = GAP_CYCLES > 0 ? 8'(GAP_CYCLES - 1) : 8'h00;
      end
      GAP: if (cnt == 8'h00) state_nx = IDLE;
           else cnt_nx = cnt - 8'h01;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      held <= '0;
      id <= 1'b0;
      cnt <= '0;
      tx_data <= '0;
      trmt <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      held <= held_nx;
      id <= id_nx;
      cnt <= cnt_nx;
      tx_data <= tx_data_nx;
      trmt <= trmt_nx;
      done0 <= done0_nx;
      done1 <= done1_nx;
      busy <= state_nx != IDLE;
    end
  end
`ifdef UART_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last <= 1'b1;
    else last <= last_nx;
  end
`endif
endmodule
